exception_controller: RTL

Multi-cycle CPU exception sequencer. It samples per-instruction exception requests and ERET from the datapath, and drives the CP0 register block write port (EPC, Cause.ExcCode, Status.EXL set) plus the ERET clear strobe. It redirects the PC to the handler vector or back to EPC, and holds the datapath while a sequence is in flight.

---
 rtl/exception_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/exception_controller.sv
// Multi-cycle exception/ERET sequencer driving the CP0 write port and PC redirect.
// Optional macro EXC_OVERFLOW_EN lets the ov request take part in priority (ExcCode 12).
module exception_controller #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adel,
  input  logic        ades,
  input  logic        syscall,
  input  logic        brk,
  input  logic        ri,
  input  logic        ov,
  input  logic        eret,
  input  logic [31:0] exc_pc,
  input  logic        status_exl,
  input  logic [31:0] epc_from_cp0,
  output logic        cp0_wen,
  output logic [31:0] cp0_epc,
  output logic [4:0]  cp0_exccode,
  output logic        eret_executed,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cpu_hold,
  output logic [15:0] exc_count
);

  typedef enum logic [1:0] {IDLE, WRITE, REDIRECT, ERET_RET} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_ov;
  logic        w_req;
  logic [4:0]  w_code;

  logic        r_cp0_wen;
  logic        r_eret_executed;
  logic        r_redirect_valid;
  logic [31:0] r_cp0_epc;
  logic [4:0]  r_cp0_exccode;
  logic [31:0] r_redirect_pc;
  logic [15:0] r_exc_count;

`ifdef EXC_OVERFLOW_EN
  assign w_ov = ov;
`else
  assign w_ov = ov & 1'b0;
`endif

  assign w_req = adel | ri | syscall | brk | w_ov | ades;

  always_comb begin
    w_code = 5'd0;
    if (adel)         w_code = 5'd4;
    else if (ri)      w_code = 5'd10;
    else if (syscall) w_code = 5'd8;
    else if (brk)     w_code = 5'd9;
    else if (w_ov)    w_code = 5'd12;
    else if (ades)    w_code = 5'd5;
  end

  // A nested exception (EXL already set) skips the CP0 write so EPC is preserved.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req)     w_next = status_exl ? REDIRECT : WRITE;
        else if (eret) w_next = ERET_RET;
      end
      WRITE:    w_next = REDIRECT;
      REDIRECT: w_next = IDLE;
      ERET_RET: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cp0_wen        <= 1'b0;
      r_eret_executed  <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_cp0_epc        <= 32'd0;
      r_cp0_exccode    <= 5'd0;
      r_redirect_pc    <= 32'd0;
      r_exc_count      <= 16'd0;
    end else begin
      r_state          <= w_next;
      r_cp0_wen        <= (w_next == WRITE);
      r_eret_executed  <= (w_next == ERET_RET);
      r_redirect_valid <= (w_next == REDIRECT) || (w_next == ERET_RET);
      if (w_next == WRITE) begin
        r_cp0_epc     <= exc_pc;
        r_cp0_exccode <= w_code;
      end
      if (w_next == REDIRECT) begin
        r_redirect_pc <= EXC_VECTOR;
        if (r_exc_count != 16'hFFFF) r_exc_count <= r_exc_count + 16'd1;
      end
      // Hold the EPC target after the ERET cycle, which reads it live.
      if (r_state == ERET_RET) r_redirect_pc <= epc_from_cp0;
    end
  end

  assign cp0_wen        = r_cp0_wen;
  assign cp0_epc        = r_cp0_epc;
  assign cp0_exccode    = r_cp0_exccode;
  assign eret_executed  = r_eret_executed;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = (r_state == ERET_RET) ? epc_from_cp0 : r_redirect_pc;
  assign cpu_hold       = (r_state != IDLE);
  assign exc_count      = r_exc_count;

endmodule
